// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : instruction_fetch_unit
// Brief  : IF stage - PC, IF/ID register, direct-mapped BTB of 2-bit counters
// Rev    : 1.0  initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter int                   BIT_WIDTH       = 32,
  parameter int                   BTB_INDEX_WIDTH = 4,
  parameter logic [BIT_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PC_write,
  input  logic                 IDIF_write,
  output logic [BIT_WIDTH-1:0] imem_addr,
  input  logic [BIT_WIDTH-1:0] imem_data,
  input  logic                 ex_branch,
  input  logic                 ex_taken,
  input  logic [BIT_WIDTH-1:0] ex_pc,
  input  logic [BIT_WIDTH-1:0] ex_target,
  input  logic                 ex_pred_taken,
  output logic [BIT_WIDTH-1:0] id_instr,
  output logic [BIT_WIDTH-1:0] id_pc_plus4,
  output logic                 id_pred_taken,
  output logic                 id_valid,
  output logic                 mispredict
);

  localparam int                   ENTRIES     = 1 << BTB_INDEX_WIDTH;
  localparam int                   TAG_W       = BIT_WIDTH - BTB_INDEX_WIDTH - 2;
  localparam logic [BIT_WIDTH-1:0] c_PC_STEP   = BIT_WIDTH'(4);
  localparam logic [1:0]           c_CTR_RESET = 2'b01;
  localparam logic [1:0]           c_CTR_ALLOC = 2'b10;

  logic [BIT_WIDTH-1:0] pc_q, pc_d;
  logic [BIT_WIDTH-1:0] id_instr_q, id_instr_d;
  logic [BIT_WIDTH-1:0] id_pc_plus4_q, id_pc_plus4_d;
  logic                 id_pred_q, id_pred_d;
  logic                 id_valid_q, id_valid_d;

  logic                 btb_valid_q [ENTRIES];
  logic [TAG_W-1:0]     btb_tag_q   [ENTRIES];
  logic [BIT_WIDTH-1:0] btb_tgt_q   [ENTRIES];
  logic [1:0]           btb_ctr_q   [ENTRIES];

  logic [BTB_INDEX_WIDTH-1:0] w_if_idx, w_ex_idx;
  logic [TAG_W-1:0]           w_if_tag, w_ex_tag;
  logic                       w_if_hit, w_pred_taken, w_ex_hit, w_mispredict;
  logic [BIT_WIDTH-1:0]       w_pc_plus4, w_next_pc, w_correct_pc;
  logic [1:0]                 w_ctr_cur, w_ctr_upd;

  assign w_if_idx     = pc_q[BTB_INDEX_WIDTH+1:2];
  assign w_if_tag     = pc_q[BIT_WIDTH-1:BTB_INDEX_WIDTH+2];
  assign w_if_hit     = btb_valid_q[w_if_idx] && (btb_tag_q[w_if_idx] == w_if_tag);
  assign w_pred_taken = w_if_hit && btb_ctr_q[w_if_idx][1];
  assign w_pc_plus4   = pc_q + c_PC_STEP;
  assign w_next_pc    = w_pred_taken ? btb_tgt_q[w_if_idx] : w_pc_plus4;

  assign w_ex_idx     = ex_pc[BTB_INDEX_WIDTH+1:2];
  assign w_ex_tag     = ex_pc[BIT_WIDTH-1:BTB_INDEX_WIDTH+2];
  assign w_ex_hit     = btb_valid_q[w_ex_idx] && (btb_tag_q[w_ex_idx] == w_ex_tag);
  assign w_mispredict = ex_branch && (ex_taken != ex_pred_taken);
  assign w_correct_pc = ex_taken ? ex_target : (ex_pc + c_PC_STEP);

  // Saturating 2-bit counter step for the resolving branch's entry.
  assign w_ctr_cur = btb_ctr_q[w_ex_idx];
  always_comb begin
    w_ctr_upd = w_ctr_cur;
    if (ex_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_upd = w_ctr_cur + 2'b01;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_upd = w_ctr_cur - 2'b01;
    end
  end

  // A mispredict flushes IF/ID and redirects even while the hazard unit stalls.
  always_comb begin
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_pred_d     = id_pred_q;
    id_valid_d    = id_valid_q;
    if (w_mispredict) begin
      pc_d          = w_correct_pc;
      id_instr_d    = '0;
      id_pc_plus4_d = '0;
      id_pred_d     = 1'b0;
      id_valid_d    = 1'b0;
    end else begin
      if (PC_write) pc_d = w_next_pc;
      if (IDIF_write) begin
        id_instr_d    = imem_data;
        id_pc_plus4_d = w_pc_plus4;
        id_pred_d     = w_pred_taken;
        id_valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      id_instr_q    <= '0;
      id_pc_plus4_q <= '0;
      id_pred_q     <= 1'b0;
      id_valid_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_pred_q     <= id_pred_d;
      id_valid_q    <= id_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= '0;
        btb_ctr_q[i]   <= c_CTR_RESET;
      end
    end else if (ex_branch) begin
      if (w_ex_hit) begin
        btb_ctr_q[w_ex_idx] <= w_ctr_upd;
        if (ex_taken) btb_tgt_q[w_ex_idx] <= ex_target;
      end else if (ex_taken) begin
        btb_valid_q[w_ex_idx] <= 1'b1;
        btb_tag_q[w_ex_idx]   <= w_ex_tag;
        btb_tgt_q[w_ex_idx]   <= ex_target;
        btb_ctr_q[w_ex_idx]   <= c_CTR_ALLOC;
      end
    end
  end

  assign imem_addr     = pc_q;
  assign mispredict    = w_mispredict;
  assign id_instr      = id_instr_q;
  assign id_pc_plus4   = id_pc_plus4_q;
  assign id_pred_taken = id_pred_q;
  assign id_valid      = id_valid_q;

endmodule
`default_nettype wire
